// File: rtl/fifo_reader.sv
// Read-side FIFO consumer: pops one word at a time and presents it on
// data_2 for DWELL cycles, with parity, a consumed-word count and a drained flag.
module fifo_reader #(
  parameter int DATA_W = 16,
  parameter int DWELL  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              buffer_empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] data_2,
  output logic              data_2_valid,
  output logic              parity,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              drained
);

  // A zero dwell would never leave S_HOLD, so it is clamped to one cycle.
  localparam int DW   = (DWELL < 1) ? 1 : DWELL;
  localparam int DC_W = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [DC_W-1:0] DLAST = DC_W'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_LATCH,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DC_W-1:0]   r_cnt;
  logic              r_rd_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_parity;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_drained;
  logic              w_go;
  logic              w_done;

  assign w_go   = en & ~buffer_empty;
  assign w_done = (r_cnt == DLAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go) w_next = S_REQ;
      S_REQ:   w_next = S_LATCH;
      S_LATCH: w_next = S_HOLD;
      S_HOLD:  if (w_done) w_next = w_go ? S_REQ : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_parity  <= 1'b0;
      r_wcnt    <= '0;
      r_drained <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rd_en   <= (w_next == S_REQ);
      r_valid   <= (w_next == S_HOLD);
      r_drained <= (r_state == S_IDLE) & buffer_empty;
      if (r_state == S_LATCH) begin
        r_data   <= rd_data;
        r_parity <= ^rd_data;
        r_wcnt   <= r_wcnt + 1'b1;
        r_cnt    <= '0;
      end else if (r_state == S_HOLD) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rd_en        = r_rd_en;
  assign data_2       = r_data;
  assign data_2_valid = r_valid;
  assign parity       = r_parity;
  assign word_cnt     = r_wcnt;
  assign drained      = r_drained;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue FIFO model feeds the DUT and
// expected words are matched against words seen on data_2.
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        buffer_empty = 1'b1;
  logic [15:0] rd_data = 16'hFFFF;
  logic        rd_en, data_2_valid, parity, drained;
  logic [15:0] data_2;
  logic [7:0]  word_cnt;

  logic        rst1 = 1'b0;
  logic        en1 = 1'b0;
  logic        be1 = 1'b1;
  logic [15:0] rd1 = 16'h1234;
  logic        rd_en1, v1, p1, dr1;
  logic [15:0] d1;
  logic [7:0]  wc1;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_d[$];
  logic        got_p[$];
  logic [7:0]  got_wc[$];
  int rden_t[$];
  int lat_q[$];
  int len_q[$];
  int last_rd = 0;
  int run = 0;
  int pop_empty = 0;
  logic pv = 1'b0;
  int rd1_t[$];
  int len1_q[$];
  int run1 = 0;
  logic pv1 = 1'b0;
  logic [7:0] exp_wc = 8'd0;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(16), .DWELL(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .buffer_empty(buffer_empty),
    .rd_data(rd_data), .rd_en(rd_en), .data_2(data_2),
    .data_2_valid(data_2_valid), .parity(parity),
    .word_cnt(word_cnt), .drained(drained)
  );

  fifo_reader #(.DATA_W(16), .DWELL(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst1), .en(en1), .buffer_empty(be1),
    .rd_data(rd1), .rd_en(rd_en1), .data_2(d1),
    .data_2_valid(v1), .parity(p1),
    .word_cnt(wc1), .drained(dr1)
  );

  // FIFO model: data appears the cycle after rd_en, empty flag is registered
  always @(posedge clk) begin
    cyc++;
    if (rd_en && fifo_q.size() != 0) rd_data <= fifo_q.pop_front();
    buffer_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (rd_en) begin
      rden_t.push_back(cyc);
      last_rd = cyc;
      if (fifo_q.size() == 0) pop_empty++;
    end
    if (data_2_valid && !pv) begin
      got_d.push_back(data_2);
      got_p.push_back(parity);
      got_wc.push_back(word_cnt);
      lat_q.push_back(cyc - last_rd);
      run = 1;
    end else if (data_2_valid) begin
      run++;
    end else if (pv) begin
      len_q.push_back(run);
    end
    pv = data_2_valid;
    if (rd_en1) rd1_t.push_back(cyc);
    if (v1) run1++;
    else if (pv1) begin
      len1_q.push_back(run1);
      run1 = 0;
    end
    pv1 = v1;
  end

  task automatic clr();
    rden_t.delete();
    lat_q.delete();
    len_q.delete();
    got_d.delete();
    got_p.delete();
    got_wc.delete();
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    @(negedge clk);
    en = 1'b1;
    rst = 1'b0;
    push(16'h0007);
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({rd_en, data_2, data_2_valid, parity, word_cnt, drained} !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_outs: got %h want 0",
          {rd_en, data_2, data_2_valid, parity, word_cnt, drained});
      end
    end
    n_tests++;
    if (rden_t.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_rden: got %0d pulses want 0", rden_t.size());
    end
  endtask

  task automatic test_single();
    logic [15:0] e;
    rst = 1'b1;
    repeat (15) @(negedge clk);
    n_tests++;
    if (got_d.size() !== 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d want 1", got_d.size());
    end else begin
      e = exp_q.pop_front();
      exp_wc++;
      n_tests++;
      if (got_d[0] !== e || got_p[0] !== ^e) begin
        n_fail++;
        $display("FAIL single_word: got %h/%b want %h/%b", got_d[0], got_p[0], e, ^e);
      end
      n_tests++;
      if (lat_q[0] !== 2) begin
        n_fail++;
        $display("FAIL single_lat: got %0d want 2", lat_q[0]);
      end
    end
    n_tests++;
    if (len_q.size() !== 1 || len_q[0] !== 4) begin
      n_fail++;
      $display("FAIL single_dwell: got %0d holds want 1x4", len_q.size());
    end
    n_tests++;
    if (word_cnt !== exp_wc || drained !== 1'b1) begin
      n_fail++;
      $display("FAIL single_end: got cnt=%0d dr=%b want %0d/1", word_cnt, drained, exp_wc);
    end
    clr();
  endtask

  task automatic test_burst();
    logic [15:0] e;
    @(negedge clk);
    push(16'h0001);
    push(16'h0003);
    push(16'hABCD);
    repeat (30) @(negedge clk);
    n_tests++;
    if (got_d.size() !== 3) begin
      n_fail++;
      $display("FAIL burst_count: got %0d want 3", got_d.size());
    end
    while (got_d.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_wc++;
      n_tests++;
      if (got_d[0] !== e || got_p[0] !== ^e || len_q[0] !== 4) begin
        n_fail++;
        $display("FAIL burst_word: got %h/%b/%0d want %h/%b/4",
          got_d[0], got_p[0], len_q[0], e, ^e);
      end
      void'(got_d.pop_front());
      void'(got_p.pop_front());
      void'(len_q.pop_front());
    end
    n_tests++;
    if (rden_t.size() !== 3 || rden_t[1] - rden_t[0] !== 6 || rden_t[2] - rden_t[1] !== 6) begin
      n_fail++;
      $display("FAIL burst_period: got %0d pulses want 3 spaced 6", rden_t.size());
    end
    n_tests++;
    if (word_cnt !== exp_wc || drained !== 1'b1 || pop_empty !== 0) begin
      n_fail++;
      $display("FAIL burst_end: got cnt=%0d dr=%b pe=%0d want %0d/1/0",
        word_cnt, drained, pop_empty, exp_wc);
    end
    clr();
  endtask

  task automatic test_en_drop();
    logic [15:0] e;
    int k;
    @(negedge clk);
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    k = 0;
    while (!data_2_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL endrop_timeout: got no valid want valid within 20");
    end
    en = 1'b0;
    repeat (15) @(negedge clk);
    e = exp_q.pop_front();
    exp_wc++;
    n_tests++;
    if (got_d.size() !== 1 || got_d[0] !== e || len_q[0] !== 4) begin
      n_fail++;
      $display("FAIL endrop_word: got %0d words want 1 of %h held 4", got_d.size(), e);
    end
    n_tests++;
    if (rden_t.size() !== 1 || drained !== 1'b0 || data_2_valid !== 1'b0 || data_2 !== e) begin
      n_fail++;
      $display("FAIL endrop_idle: got rd=%0d dr=%b v=%b d=%h want 1/0/0/%h",
        rden_t.size(), drained, data_2_valid, data_2, e);
    end
    clr();
    en = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_d.size() !== 2) begin
      n_fail++;
      $display("FAIL endrop_resume: got %0d words want 2", got_d.size());
    end
    while (got_d.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_wc++;
      n_tests++;
      if (got_d[0] !== e) begin
        n_fail++;
        $display("FAIL endrop_data: got %h want %h", got_d[0], e);
      end
      void'(got_d.pop_front());
    end
    clr();
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    push(16'h5A5A);
    k = 0;
    while (!rd_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({data_2, data_2_valid, word_cnt, rd_en} !== 26'h0) begin
      n_fail++;
      $display("FAIL rstmid_outs: got d=%h v=%b c=%0d rd=%b want 0",
        data_2, data_2_valid, word_cnt, rd_en);
    end
    void'(exp_q.pop_front());
    exp_wc = 8'd0;
    rst = 1'b1;
    clr();
    push(16'hC3C3);
    repeat (16) @(negedge clk);
    n_tests++;
    if (got_d.size() !== 1 || got_d[0] !== exp_q[0] || word_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL rstmid_restart: got n=%0d c=%0d want 1 word C3C3 c=1",
        got_d.size(), word_cnt);
    end
    void'(exp_q.pop_front());
    clr();
  endtask

  task automatic test_wrap();
    int bad;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clr();
    exp_wc = 8'd0;
    for (int i = 0; i < 257; i++) push(16'((i * 97 + 5) ^ (i << 9)));
    repeat (1570) @(negedge clk);
    n_tests++;
    if (got_d.size() !== 257) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d want 257", got_d.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 257; i++) begin
        exp_wc++;
        if (got_d[i] !== exp_q[i] || got_p[i] !== ^exp_q[i] || got_wc[i] !== exp_wc) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL wrap_data: got %0d bad words want 0", bad);
      end
      n_tests++;
      if (got_wc[254] !== 8'd255 || got_wc[255] !== 8'd0 || got_wc[256] !== 8'd1) begin
        n_fail++;
        $display("FAIL wrap_cnt: got %0d,%0d,%0d want 255,0,1",
          got_wc[254], got_wc[255], got_wc[256]);
      end
    end
    exp_q.delete();
    clr();
  endtask

  task automatic test_dwell0();
    int bad;
    @(negedge clk);
    en1 = 1'b1;
    be1 = 1'b0;
    rst1 = 1'b1;
    repeat (20) @(negedge clk);
    en1 = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (len1_q.size() < 5) begin
      n_fail++;
      $display("FAIL dw0_count: got %0d words want >=5", len1_q.size());
    end
    bad = 0;
    foreach (len1_q[i]) if (len1_q[i] !== 1) bad++;
    for (int i = 1; i < rd1_t.size(); i++) if (rd1_t[i] - rd1_t[i-1] !== 3) bad++;
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL dw0_timing: got %0d bad holds/gaps want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_en_drop();
    test_reset_mid();
    test_wrap();
    test_dwell0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
